// File: rtl/jtpopeye_inputs.sv
// jtpopeye_inputs: cabinet input conditioner for the Popeye core.
//
// Decodes PS/2 key events into per-key press registers, merges them with the
// HPS joystick words, resolves opposing directions (SOCD) and registers the
// result as active-low player controls. Also produces a fixed-width coin pulse
// and a toggling pause flag.
//
// Ports:
//   clk           system clock (40 MHz)
//   rst_n         asynchronous active-low reset
//   ps2_key       [10] event toggle, [9] pressed, [8] extended (ignored), [7:0] code
//   joy_0         player-1 HPS joystick, active high (dirs, punch, starts, coin, pause)
//   joy_1         player-2 HPS joystick, active high (dirs, punch)
//   downloading   ROM download active; forces every control inactive
//   clr_pause     synchronous pause clear
//   joystick1/2   active-low {punch,up,down,left,right}
//   start_button  active-low {start2,start1}
//   coin_input    active-low coin pulse, COIN_LEN cycles wide
//   pause         active-high pause flag
module jtpopeye_inputs #(
    parameter int unsigned   CW       = 20,
    parameter logic [CW-1:0] COIN_LEN = 20'd800000,
    parameter bit            SOCD_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy_0,
    input  logic [15:0] joy_1,
    input  logic        downloading,
    input  logic        clr_pause,
    output logic [4:0]  joystick1,
    output logic [4:0]  joystick2,
    output logic [1:0]  start_button,
    output logic        coin_input,
    output logic        pause
);

    // Key register indices
    localparam int unsigned KRight  = 0;
    localparam int unsigned KLeft   = 1;
    localparam int unsigned KDown   = 2;
    localparam int unsigned KUp     = 3;
    localparam int unsigned KPunch  = 4;
    localparam int unsigned KStart1 = 5;
    localparam int unsigned KStart2 = 6;
    localparam int unsigned KCoin   = 7;
    localparam int unsigned KPause  = 8;

    typedef enum logic [1:0] {StIdle, StPulse, StWaitRel} coin_st_e;

    logic          tog_q;
    logic [8:0]    keys_q, keys_d;
    logic [4:0]    joy1_q, joy1_d;
    logic [4:0]    joy2_q, joy2_d;
    logic [1:0]    start_q, start_d;
    logic          coin_q, coin_d;
    logic          pause_q, pause_d;
    logic          coin_req_q, pause_req_q;
    logic [CW-1:0] cnt_q, cnt_d;
    coin_st_e      coin_st_q, coin_st_d;

    logic          ps2_evt;
    logic [4:0]    p1_req, p2_req;
    logic [1:0]    start_req;
    logic          coin_req, pause_req;
    logic          coin_rise, pause_rise;

    logic unused_inputs;
    assign unused_inputs = ^{ps2_key[8], joy_0[15:10], joy_0[5], joy_1[15:5]};

    // Opposing directions cancel to neutral; bit order {punch,up,down,left,right}.
    function automatic logic [4:0] socd(input logic [4:0] req);
        logic [4:0] res;
        res = req;
        if (SOCD_EN) begin
            if (req[0] && req[1]) res[1:0] = 2'b00;
            if (req[2] && req[3]) res[3:2] = 2'b00;
        end
        return res;
    endfunction

    // ---------------------------------------------------------------- PS/2 keys
    assign ps2_evt = ps2_key[10] ^ tog_q;

    always_comb begin
        keys_d = keys_q;
        if (ps2_evt) begin
            case (ps2_key[7:0])
                8'h75:   keys_d[KUp]     = ps2_key[9];
                8'h72:   keys_d[KDown]   = ps2_key[9];
                8'h6B:   keys_d[KLeft]   = ps2_key[9];
                8'h74:   keys_d[KRight]  = ps2_key[9];
                8'h05:   keys_d[KStart1] = ps2_key[9];
                8'h06:   keys_d[KStart2] = ps2_key[9];
                8'h04:   keys_d[KCoin]   = ps2_key[9];
                8'h0C:   keys_d[KPause]  = ps2_key[9];
                8'h14:   keys_d[KPunch]  = ps2_key[9];
                default: ;
            endcase
        end
        if (downloading) keys_d = '0;
    end

    // ------------------------------------------------------------------ merge
    always_comb begin
        p1_req = {keys_q[KPunch] | joy_0[4], keys_q[KUp] | joy_0[3], keys_q[KDown] | joy_0[2],
                  keys_q[KLeft] | joy_0[1], keys_q[KRight] | joy_0[0]};
        p2_req    = joy_1[4:0];
        start_req = {keys_q[KStart2] | joy_0[7], keys_q[KStart1] | joy_0[6]};
        coin_req  = keys_q[KCoin] | joy_0[8];
        pause_req = keys_q[KPause] | joy_0[9];
    end

    // Edge detectors keep tracking while downloading so a request held across
    // the end of a download does not fire.
    assign coin_rise  = coin_req & ~coin_req_q;
    assign pause_rise = pause_req & ~pause_req_q;

    always_comb begin
        joy1_d  = ~socd(p1_req);
        joy2_d  = ~socd(p2_req);
        start_d = ~start_req;
        if (downloading) begin
            joy1_d  = 5'h1F;
            joy2_d  = 5'h1F;
            start_d = 2'b11;
        end
    end

    // Clear wins over a simultaneous toggle.
    always_comb begin
        pause_d = pause_q;
        if (pause_rise) pause_d = ~pause_q;
        if (clr_pause || downloading) pause_d = 1'b0;
    end

    // --------------------------------------------------------------- coin FSM
    always_comb begin
        coin_st_d = coin_st_q;
        case (coin_st_q)
            StIdle:    if (coin_rise) coin_st_d = StPulse;
            StPulse:   if (cnt_q == '0) coin_st_d = coin_req ? StWaitRel : StIdle;
            StWaitRel: if (!coin_req) coin_st_d = StIdle;
            default:   coin_st_d = StIdle;
        endcase
        if (downloading) coin_st_d = StIdle;
    end

    // Counter loads COIN_LEN-1 on the triggering edge, so the low time spans
    // exactly COIN_LEN edges including that one.
    always_comb begin
        cnt_d  = cnt_q;
        coin_d = 1'b1;
        case (coin_st_q)
            StIdle: begin
                if (coin_rise) begin
                    cnt_d  = COIN_LEN - CW'(1);
                    coin_d = 1'b0;
                end
            end
            StPulse: begin
                if (cnt_q != '0) begin
                    cnt_d  = cnt_q - CW'(1);
                    coin_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (downloading) begin
            cnt_d  = '0;
            coin_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coin_st_q <= StIdle;
        end else begin
            coin_st_q <= coin_st_d;
        end
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // History follows the live toggle through reset: no event on release.
            tog_q       <= ps2_key[10];
            keys_q      <= '0;
            joy1_q      <= 5'h1F;
            joy2_q      <= 5'h1F;
            start_q     <= 2'b11;
            coin_q      <= 1'b1;
            pause_q     <= 1'b0;
            coin_req_q  <= 1'b0;
            pause_req_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            tog_q       <= ps2_key[10];
            keys_q      <= keys_d;
            joy1_q      <= joy1_d;
            joy2_q      <= joy2_d;
            start_q     <= start_d;
            coin_q      <= coin_d;
            pause_q     <= pause_d;
            coin_req_q  <= coin_req;
            pause_req_q <= pause_req;
            cnt_q       <= cnt_d;
        end
    end

    assign joystick1    = joy1_q;
    assign joystick2    = joy2_q;
    assign start_button = start_q;
    assign coin_input   = coin_q;
    assign pause        = pause_q;

endmodule

// File: tb/tb_jtpopeye_inputs.sv
// Self-checking bench for jtpopeye_inputs. Two instances share the stimulus:
// u_dut with SOCD enabled and u_dut_nosocd with it disabled. Expected output
// snapshots are queued with a due cycle and compared at the falling edge.
module tb_jtpopeye_inputs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] ps2_key;
    logic [15:0] joy_0, joy_1;
    logic        downloading, clr_pause;
    logic [4:0]  joystick1, joystick2, joystick1_b, joystick2_b;
    logic [1:0]  start_button, unused_start_b;
    logic        coin_input, pause, unused_coin_b, unused_pause_b;

    always #5 clk = ~clk;

    jtpopeye_inputs #(.CW(8), .COIN_LEN(8'd5), .SOCD_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ps2_key(ps2_key), .joy_0(joy_0), .joy_1(joy_1),
        .downloading(downloading), .clr_pause(clr_pause), .joystick1(joystick1),
        .joystick2(joystick2), .start_button(start_button), .coin_input(coin_input),
        .pause(pause)
    );

    jtpopeye_inputs #(.CW(8), .COIN_LEN(8'd5), .SOCD_EN(1'b0)) u_dut_nosocd (
        .clk(clk), .rst_n(rst_n), .ps2_key(ps2_key), .joy_0(joy_0), .joy_1(joy_1),
        .downloading(downloading), .clr_pause(clr_pause), .joystick1(joystick1_b),
        .joystick2(joystick2_b), .start_button(unused_start_b), .coin_input(unused_coin_b),
        .pause(unused_pause_b)
    );

    // Snapshot layout {j1b, j2b, j1, j2, start, coin, pause}
    localparam logic [23:0] MJ1B   = 24'hF80000;
    localparam logic [23:0] MJ2B   = 24'h07C000;
    localparam logic [23:0] MJ1    = 24'h003E00;
    localparam logic [23:0] MJ2    = 24'h0001F0;
    localparam logic [23:0] MST    = 24'h00000C;
    localparam logic [23:0] MCOIN  = 24'h000002;
    localparam logic [23:0] MPAUSE = 24'h000001;
    localparam logic [23:0] MALL   = 24'hFFFFFF;

    logic [23:0] snap;
    assign snap = {joystick1_b, joystick2_b, joystick1, joystick2, start_button, coin_input, pause};

    typedef struct {
        string       name;
        int          due;
        logic [23:0] val;
        logic [23:0] mask;
    } exp_t;

    typedef struct packed {
        logic [15:0] j0;
        logic [15:0] j1;
        logic [4:0]  e1;
        logic [4:0]  e1b;
        logic [4:0]  e2;
        logic [4:0]  e2b;
        logic [1:0]  st;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] mk(input logic [4:0] j1b, input logic [4:0] j2b,
                                       input logic [4:0] j1, input logic [4:0] j2,
                                       input logic [1:0] st, input logic coin,
                                       input logic pse);
        return {j1b, j2b, j1, j2, st, coin, pse};
    endfunction

    task automatic push_exp(input string name, input int lat, input logic [23:0] val,
                            input logic [23:0] mask);
        exp_t e;
        int   idx;
        e.name = name;
        e.due  = cyc + lat;
        e.val  = val;
        e.mask = mask;
        idx    = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].due > e.due) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic exp_joy(input string name, input int lat, input logic [4:0] j1,
                           input logic [4:0] j1b, input logic [4:0] j2, input logic [4:0] j2b);
        push_exp(name, lat, mk(j1b, j2b, j1, j2, 2'b00, 1'b0, 1'b0), MJ1 | MJ1B | MJ2 | MJ2B);
    endtask

    task automatic exp_coin(input string name, input int lat, input logic coin);
        push_exp(name, lat, mk(5'h0, 5'h0, 5'h0, 5'h0, 2'b00, coin, 1'b0), MCOIN);
    endtask

    task automatic exp_pause(input string name, input int lat, input logic pse);
        push_exp(name, lat, mk(5'h0, 5'h0, 5'h0, 5'h0, 2'b00, 1'b0, pse), MPAUSE);
    endtask

    task automatic check_now(input string name, input logic [23:0] got, input logic [23:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    // Scoreboard: compare every entry that has come due.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if ((snap & e.mask) !== (e.val & e.mask)) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%h want=%h mask=%h", e.name, cyc,
                         snap & e.mask, e.val & e.mask, e.mask);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ps2_send(input logic [7:0] code, input logic pressed);
        logic t;
        t       = ps2_key[10];
        ps2_key = {~t, pressed, 1'b0, code};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t pending=%0d", $time, sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        //            j0        j1        e1     e1b    e2     e2b    st
        vecs[0] = '{16'h0000, 16'h0000, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 2'b11};
        vecs[1] = '{16'h0001, 16'h0000, 5'h1E, 5'h1E, 5'h1F, 5'h1F, 2'b11};
        vecs[2] = '{16'h0003, 16'h0000, 5'h1F, 5'h1C, 5'h1F, 5'h1F, 2'b11};
        vecs[3] = '{16'h000C, 16'h0000, 5'h1F, 5'h13, 5'h1F, 5'h1F, 2'b11};
        vecs[4] = '{16'h0015, 16'h0000, 5'h0A, 5'h0A, 5'h1F, 5'h1F, 2'b11};
        vecs[5] = '{16'h0040, 16'h0000, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 2'b10};
        vecs[6] = '{16'h0080, 16'h0000, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 2'b01};
        vecs[7] = '{16'h000A, 16'h001F, 5'h15, 5'h15, 5'h0F, 5'h00, 2'b11};
        vecs[8] = '{16'h0000, 16'h0012, 5'h1F, 5'h1F, 5'h0D, 5'h0D, 2'b11};
        vecs[9] = '{16'h00C2, 16'h0005, 5'h1D, 5'h1D, 5'h1A, 5'h1A, 2'b00};

        // Reset with a pending-looking toggle already high on ps2_key
        rst_n       = 1'b0;
        ps2_key     = {1'b1, 1'b1, 1'b0, 8'h75};
        joy_0       = '0;
        joy_1       = '0;
        downloading = 1'b0;
        clr_pause   = 1'b0;
        #12;
        check_now("reset_state", snap, mk(5'h1F, 5'h1F, 5'h1F, 5'h1F, 2'b11, 1'b1, 1'b0));
        step();
        rst_n = 1'b1;
        for (int l = 1; l <= 3; l++) exp_joy("no_spurious_evt", l, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
        steps(3);

        // Joystick table, 1-cycle latency
        foreach (vecs[i]) begin
            joy_0 = vecs[i].j0;
            joy_1 = vecs[i].j1;
            push_exp($sformatf("vec%0d", i), 1,
                     mk(vecs[i].e1b, vecs[i].e2b, vecs[i].e1, vecs[i].e2, vecs[i].st, 1'b0, 1'b0),
                     MJ1 | MJ1B | MJ2 | MJ2B | MST);
            step();
        end
        joy_0 = '0;
        joy_1 = '0;
        steps(2);

        // PS/2 decode, 2-cycle latency
        ps2_send(8'h75, 1'b1);
        exp_joy("ps2_up_lat1", 1, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
        exp_joy("ps2_up_press", 2, 5'h17, 5'h17, 5'h1F, 5'h1F);
        steps(2);
        ps2_send(8'h75, 1'b0);
        exp_joy("ps2_up_release", 2, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
        steps(2);
        ps2_send(8'h1C, 1'b1);
        exp_joy("ps2_unmapped", 2, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
        steps(2);
        ps2_send(8'h14, 1'b1);
        exp_joy("ps2_punch", 2, 5'h0F, 5'h0F, 5'h1F, 5'h1F);
        steps(2);
        ps2_send(8'h14, 1'b0);
        exp_joy("ps2_punch_rel", 2, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
        steps(2);
        ps2_send(8'h6B, 1'b1);
        exp_joy("ps2_left", 2, 5'h1D, 5'h1D, 5'h1F, 5'h1F);
        steps(2);
        joy_0 = 16'h0001;
        exp_joy("key_joy_socd", 1, 5'h1F, 5'h1C, 5'h1F, 5'h1F);
        step();
        joy_0 = '0;
        ps2_send(8'h6B, 1'b0);
        exp_joy("ps2_left_rel", 2, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
        steps(2);

        // Coin: held request gives a single 5-cycle pulse
        joy_0 = 16'h0100;
        for (int i = 1; i <= 20; i++) exp_coin($sformatf("coin_hold_%0d", i), i, (i <= 5) ? 1'b0 : 1'b1);
        steps(20);
        joy_0 = '0;
        exp_coin("coin_released", 1, 1'b1);
        steps(2);
        joy_0 = 16'h0100;
        for (int i = 1; i <= 8; i++) exp_coin($sformatf("coin_again_%0d", i), i, (i <= 5) ? 1'b0 : 1'b1);
        steps(8);
        joy_0 = '0;
        steps(2);
        // Re-press during the pulse is ignored
        joy_0 = 16'h0100;
        for (int i = 1; i <= 9; i++) exp_coin($sformatf("coin_repress_%0d", i), i, (i <= 5) ? 1'b0 : 1'b1);
        step();
        joy_0 = '0;
        step();
        joy_0 = 16'h0100;
        step();
        joy_0 = '0;
        steps(6);

        // Pause via PS/2 code 0C
        ps2_send(8'h0C, 1'b1);
        exp_pause("pause_lat1", 1, 1'b0);
        exp_pause("pause_on", 2, 1'b1);
        steps(2);
        ps2_send(8'h0C, 1'b0);
        exp_pause("pause_held", 2, 1'b1);
        steps(2);
        ps2_send(8'h0C, 1'b1);
        exp_pause("pause_off", 2, 1'b0);
        steps(2);
        ps2_send(8'h0C, 1'b0);
        steps(2);
        // clr_pause wins over a simultaneous rising edge
        joy_0     = 16'h0200;
        clr_pause = 1'b1;
        exp_pause("clr_vs_rise", 1, 1'b0);
        step();
        clr_pause = 1'b0;
        exp_pause("held_no_retrig", 1, 1'b0);
        step();
        joy_0 = '0;
        step();
        joy_0 = 16'h0200;
        exp_pause("joy_pause_on", 1, 1'b1);
        step();
        joy_0     = '0;
        clr_pause = 1'b1;
        exp_pause("clr_pause", 1, 1'b0);
        step();
        clr_pause = 1'b0;
        step();

        // downloading during a coin pulse with a key held
        joy_0 = 16'h0200;
        exp_pause("pre_dl_pause", 1, 1'b1);
        step();
        joy_0 = '0;
        ps2_send(8'h74, 1'b1);
        exp_joy("pre_dl_right", 2, 5'h1E, 5'h1E, 5'h1F, 5'h1F);
        steps(2);
        joy_0 = 16'h0100;
        exp_coin("pre_dl_coin", 1, 1'b0);
        steps(3);
        downloading = 1'b1;
        joy_0       = 16'h0141;
        joy_1       = 16'h0010;
        for (int i = 1; i <= 4; i++)
            push_exp($sformatf("dl_forced_%0d", i), i,
                     mk(5'h1F, 5'h1F, 5'h1F, 5'h1F, 2'b11, 1'b1, 1'b0), MALL);
        steps(4);
        downloading = 1'b0;
        joy_0       = 16'h0100;
        joy_1       = '0;
        for (int i = 1; i <= 8; i++)
            push_exp($sformatf("post_dl_%0d", i), i,
                     mk(5'h1F, 5'h1F, 5'h1F, 5'h1F, 2'b11, 1'b1, 1'b0), MALL);
        steps(8);
        joy_0 = '0;
        steps(2);

        // Asynchronous reset mid-pulse with pause set
        joy_0 = 16'h0200;
        exp_pause("pre_rst_pause", 1, 1'b1);
        step();
        joy_0 = 16'h0100;
        exp_coin("pre_rst_coin", 1, 1'b0);
        steps(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", snap, mk(5'h1F, 5'h1F, 5'h1F, 5'h1F, 2'b11, 1'b1, 1'b0));
        step();
        joy_0 = '0;
        rst_n = 1'b1;
        push_exp("after_reset", 1, mk(5'h1F, 5'h1F, 5'h1F, 5'h1F, 2'b11, 1'b1, 1'b0), MALL);
        steps(2);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 50 && sb.size() > 0; i++) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtpopeye_inputs.md
Name: jtpopeye_inputs

Overview:
Cabinet input conditioner sitting directly upstream of jtpopeye_game in the MiSTer top. It decodes PS/2 key events, merges them with the HPS joystick words and produces registered, active-low player controls. It also generates a fixed-width coin pulse and a toggled pause flag. It replaces the ad-hoc input logic in the top level with a single verifiable block.

Parameters:
COIN_LEN, 20'd800000, width of the coin pulse in clk cycles (20 ms at 40 MHz); must be ≥1.
CW, 20, coin counter width in bits; COIN_LEN must fit in it.
SOCD_EN, 1, 1 = opposing directions pressed together cancel to neutral.

Ports:
clk  in  1  system clock, 40 MHz.
rst_n  in  1  asynchronous active-low reset.
ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (ignored), [7:0] scan code.
joy_0  in  16  player-1 HPS joystick, active high: [0]R [1]L [2]D [3]U [4]punch [6]start1 [7]start2 [8]coin [9]pause.
joy_1  in  16  player-2 HPS joystick, active high: [0]R [1]L [2]D [3]U [4]punch.
downloading  in  1  ROM download active; forces all controls inactive.
clr_pause  in  1  synchronous pause clear (OSD reset or button).
joystick1  out  5  active low {punch,up,down,left,right}.
joystick2  out  5  active low {punch,up,down,left,right}.
start_button  out  2  active low {start2,start1}.
coin_input  out  1  active-low coin pulse.
pause  out  1  active-high pause flag.

Behaviour:
- Reset (async, rst_n=0): all key registers cleared; joystick1=joystick2=5'h1F; start_button=2'b11; coin_input=1; pause=0; coin counter=0. The ps2_key[10] history register loads the current ps2_key[10] value, so no spurious event is generated on release of reset.
- PS/2 decode: an event is registered when ps2_key[10] differs from its registered copy. On the following clk edge, the key register selected by the code takes ps2_key[9]. Key map: 75 up, 72 down, 6B left, 74 right, 05 start1, 06 start2, 04 coin, 0C pause, 14 punch. Other codes are ignored.
- Merge: each control request is the key register OR the corresponding joy_0 bit. Player 2 uses joy_1 only.
- SOCD (SOCD_EN=1): left and right requested together gives neither; up and down together gives neither. Applied per player.
- Output registers update every cycle as the inverted request.
  - Latency from a joy change to the output: 1 cycle.
  - Latency from a PS/2 toggle to the output: 2 cycles.
- Coin FSM, states IDLE/PULSE/WAIT_REL:
  - IDLE: a rising edge of the coin request loads the counter with COIN_LEN-1 and moves to PULSE. coin_input goes low on the same edge.
  - PULSE: coin_input stays low and the counter decrements. When the counter reaches 0, coin_input goes high on the next edge. The FSM then moves to WAIT_REL if the request is still high, otherwise to IDLE.
  - WAIT_REL: returns to IDLE when the request goes low.
  - Rule: the pulse is exactly COIN_LEN cycles. A held request never retriggers. Edges during PULSE are ignored.
- Pause: a rising edge of the pause request toggles pause. clr_pause=1 forces pause=0 and takes priority over a simultaneous toggle.
- downloading=1:
  - Key registers are cleared.
  - All control outputs are forced inactive (high).
  - The coin FSM aborts to IDLE with coin_input=1.
  - pause is forced to 0.
  - Edge detectors keep tracking, so a request already held when downloading falls does not fire.
- Mid-operation reset: async reset returns all outputs to their reset values immediately, including during PULSE.

Test Plan:
- Reset, then ps2_key toggles with code 75, pressed=1 → joystick1=5'b10111 two cycles later. Same code with pressed=0 → 5'b11111.
- joy_0[0]=1 and joy_0[1]=1 with SOCD_EN=1 → joystick1[1:0]=2'b11. Repeat with SOCD_EN=0 → 2'b00.
- COIN_LEN=5; hold joy_0[8] high for 20 cycles → coin_input low for exactly 5 cycles, single pulse. Release, press again → second 5-cycle pulse.
- F4 (code 0C) press, release, press → pause goes 0→1→0. Assert clr_pause together with a pause rising edge → pause=0.
- Raise downloading during PULSE while a key is held → coin_input=1 and joystick outputs all 1 next cycle. Lower downloading with joy_0[8] still high → no coin pulse.
- Assert rst_n=0 asynchronously mid-pulse → coin_input=1 and pause=0 without waiting for a clk edge.
